fifo_pop_ctrl: RTL and testbench

- Read-side master for the fifo block: drives Fifo_rd, absorbs the FIFO's registered read latency, and re-presents popped words downstream on a valid/ready handshake.
- Pops only when the FIFO reports data and local space is guaranteed, so the FIFO never sees an underflow read and no word is lost.
- Sits between a fifo instance and the next pipeline stage (e.g. an arbiter or output port).

---
 rtl/fifo_pop_ctrl_if.sv | 30 +++
 rtl/fifo_pop_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_pop_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pop_ctrl_if.sv
// Bundle between fifo_pop_ctrl, the fifo read port it drains and the downstream
// stage. Master is the controller, slave is whoever sits around it.
interface fifo_pop_ctrl_if #(
  parameter int BITNUMBER = 6
);
  logic                 Fifo_empty;
  logic                 almost_empty;
  logic                 can_pop;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 valid_read;
  logic                 Fifo_rd_error;
  logic                 Fifo_rd;
  logic                 out_ready;
  logic [BITNUMBER-1:0] data_out;
  logic                 data_valid;

  // Downstream handshake: a word moves on every clk edge where data_valid and
  // out_ready are both 1; data_out is held stable while data_valid && !out_ready.
  modport master (
    input  Fifo_empty, almost_empty, can_pop, Fifo_Data_out, valid_read,
           Fifo_rd_error, out_ready,
    output Fifo_rd, data_out, data_valid
  );

  modport slave (
    output Fifo_empty, almost_empty, can_pop, Fifo_Data_out, valid_read,
           Fifo_rd_error, out_ready,
    input  Fifo_rd, data_out, data_valid
  );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// Read-side master for a fifo with registered read latency: issues credit-limited
// pops, catches the returning words in a small skid buffer and re-presents them.
module fifo_pop_ctrl #(
  parameter int BITNUMBER  = 6,
  parameter int SKID_DEPTH = 4,
  parameter int RD_LAT     = 2,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  fifo_pop_ctrl_if.master  bus,
  output logic             idle_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [1:0]       state_o
);
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CW:0]      DEPTH_C  = (CW+1)'(SKID_DEPTH);
  localparam logic [CW-1:0]    FULL_C   = CW'(SKID_DEPTH);
  localparam logic [PW-1:0]    LAST_PTR = PW'(SKID_DEPTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  if (SKID_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("fifo_pop_ctrl: SKID_DEPTH must be at least RD_LAT+1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WAIT  = 2'b10,
    FLUSH = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 fifo_rd_q, fifo_rd_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [BITNUMBER-1:0] mem_q [SKID_DEPTH];

  logic [CW:0] committed;
  logic        credit_ok, skid_full, spurious, overflow;
  logic        rsp_ok, wr_en, rd_en, dv, err_event;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A pop currently on Fifo_rd is not yet in outst_q, so it is charged here too.
  assign committed = {1'b0, outst_q} + {1'b0, cnt_q} + {{CW{1'b0}}, fifo_rd_q};
  assign credit_ok = committed < DEPTH_C;
  assign skid_full = (cnt_q == FULL_C);
  assign spurious  = bus.valid_read && (outst_q == '0);
  assign overflow  = bus.valid_read && skid_full;
  assign rsp_ok    = bus.valid_read && !spurious;
  assign wr_en     = rsp_ok && !skid_full;
  assign dv        = (cnt_q != '0);
  assign rd_en     = dv && bus.out_ready;
  assign err_event = bus.Fifo_rd_error || spurious || overflow;

  always_comb begin
    outst_d  = outst_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    case ({fifo_rd_q, rsp_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (err_event && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
  end

  // The almost_empty term covers the pop already on Fifo_rd, which the fifo's
  // empty flag does not reflect until the following cycle.
  always_comb begin
    state_d   = state_q;
    fifo_rd_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = READ;
      end
      READ: begin
        if (!enable_i)      state_d = FLUSH;
        else if (!credit_ok) state_d = WAIT;
        fifo_rd_d = enable_i && bus.can_pop && !bus.Fifo_empty && credit_ok &&
                    !(fifo_rd_q && bus.almost_empty);
      end
      WAIT: begin
        if (!enable_i)      state_d = FLUSH;
        else if (credit_ok) state_d = READ;
      end
      FLUSH: begin
        if (outst_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      fifo_rd_q <= 1'b0;
      outst_q   <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      fifo_rd_q <= fifo_rd_d;
      outst_q   <= outst_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[wr_ptr_q] <= bus.Fifo_Data_out;
  end

  assign bus.Fifo_rd    = fifo_rd_q;
  assign bus.data_valid = dv;
  assign bus.data_out   = dv ? mem_q[rd_ptr_q] : '0;
  assign idle_o         = (state_q == IDLE) && (outst_q == '0) && (cnt_q == '0);
  assign err_count_o    = err_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: a behavioural fifo with two-cycle read latency feeds the
// controller; words the controller must deliver are queued and checked on output.
module tb_fifo_pop_ctrl;
  localparam int W     = 6;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int EW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          idle;
  logic [EW-1:0] err_count;
  logic [1:0]    state;

  fifo_pop_ctrl_if #(.BITNUMBER(W)) bus ();

  fifo_pop_ctrl #(
    .BITNUMBER(W), .SKID_DEPTH(DEPTH), .RD_LAT(LAT), .ERR_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .bus(bus),
    .idle_o(idle), .err_count_o(err_count), .state_o(state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int  pops = 0, underflows = 0, cycle = 0, deliveries = 0;
  int  first_dlv = -1, last_dlv = -1;
  bit  force_vr = 1'b0, force_err = 1'b0;
  int  n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Fifo model: pop sampled at an edge, word returns RD_LAT cycles later.
  initial begin : fifo_model
    logic         p1_v, p2_v, rd_s, uf;
    logic [W-1:0] p1_d, p2_d;
    p1_v = 1'b0;
    p1_d = '0;
    forever begin
      @(posedge clk);
      rd_s = bus.Fifo_rd;
      uf   = 1'b0;
      p2_v = p1_v;
      p2_d = p1_d;
      p1_v = 1'b0;
      p1_d = '0;
      if (rd_s) begin
        pops++;
        if (fifo_q.size() == 0) begin
          underflows++;
          uf = 1'b1;
        end else begin
          p1_v = 1'b1;
          p1_d = fifo_q.pop_front();
        end
      end
      #1;
      bus.valid_read    = p2_v | force_vr;
      bus.Fifo_Data_out = force_vr ? W'($urandom) : p2_d;
      bus.Fifo_rd_error = uf | force_err;
      bus.Fifo_empty    = (fifo_q.size() == 0);
      bus.almost_empty  = (fifo_q.size() <= 1);
    end
  end

  initial begin : monitor
    bit           hold;
    logic [W-1:0] held, exp;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        if (hold) begin
          check("hold_valid", 32'(bus.data_valid), 32'(1));
          check("hold_data", 32'(bus.data_out), 32'(held));
        end
        if (bus.data_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %0h, expected no word", bus.data_out);
          end else begin
            exp = exp_q.pop_front();
            check("data_out", 32'(bus.data_out), 32'(exp));
          end
          deliveries++;
          if (first_dlv < 0) first_dlv = cycle;
          last_dlv = cycle;
        end
        hold = bus.data_valid && !bus.out_ready;
        held = bus.data_out;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    enable        = 1'b0;
    bus.out_ready = 1'b0;
    bus.can_pop   = 1'b1;
    force_vr      = 1'b0;
    force_err     = 1'b0;
    reset         = 1'b0;
    repeat (4) step();
    fifo_q.delete();
    exp_q.delete();
    reset = 1'b1;
    step();
    pops = 0; underflows = 0; deliveries = 0;
    first_dlv = -1; last_dlv = -1;
  endtask

  task automatic load(input int n, input bit rnd, input int nexp);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? W'($urandom) : W'(i + 1);
      fifo_q.push_back(w);
      if (i < nexp) exp_q.push_back(w);
    end
  endtask

  task automatic wait_drain(input string name, input int budget, input bit rnd);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      if (rnd) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.can_pop   = ($urandom_range(0, 3) != 0);
      end
      step();
      k++;
    end
    bus.out_ready = 1'b1;
    bus.can_pop   = 1'b1;
    check(name, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic finish_idle(input string name);
    enable = 1'b0;
    repeat (8) step();
    check({name, "_idle"}, 32'(idle), 32'(1));
    check({name, "_state"}, 32'(state), 32'(0));
    check({name, "_err"}, 32'(err_count), 32'(0));
  endtask

  initial begin : main
    int           k, n;
    logic [W-1:0] first_w;
    bus.Fifo_empty = 1'b1; bus.almost_empty = 1'b1; bus.can_pop = 1'b1;
    bus.Fifo_Data_out = '0; bus.valid_read = 1'b0; bus.Fifo_rd_error = 1'b0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (3) step();
    check("rst_fifo_rd", 32'(bus.Fifo_rd), 32'(0));
    check("rst_valid", 32'(bus.data_valid), 32'(0));
    check("rst_data", 32'(bus.data_out), 32'(0));
    check("rst_err", 32'(err_count), 32'(0));
    check("rst_idle", 32'(idle), 32'(1));
    check("rst_state", 32'(state), 32'(0));
    reset = 1'b1;
    step();

    // streaming 0x01..0x04
    do_reset();
    load(4, 1'b0, 4);
    bus.out_ready = 1'b1;
    enable = 1'b1;
    wait_drain("stream_drain", 60, 1'b0);
    finish_idle("stream");
    check("stream_pops", 32'(pops), 32'(4));
    check("stream_underflow", 32'(underflows), 32'(0));
    check("stream_span", 32'(last_dlv - first_dlv), 32'(3));

    // backpressure with 6 words
    do_reset();
    load(6, 1'b1, 6);
    first_w = exp_q[0];
    enable = 1'b1;
    repeat (20) step();
    check("bp_pops", 32'(pops), 32'(DEPTH));
    check("bp_valid", 32'(bus.data_valid), 32'(1));
    check("bp_head", 32'(bus.data_out), 32'(first_w));
    check("bp_state_wait", 32'(state), 32'(2));
    bus.out_ready = 1'b1;
    wait_drain("bp_drain", 60, 1'b0);
    finish_idle("bp");
    check("bp_pops_total", 32'(pops), 32'(6));

    // single word: almost_empty guard
    do_reset();
    load(1, 1'b1, 1);
    bus.out_ready = 1'b1;
    enable = 1'b1;
    repeat (12) step();
    check("ae_pops", 32'(pops), 32'(1));
    check("ae_underflow", 32'(underflows), 32'(0));
    wait_drain("ae_drain", 20, 1'b0);
    finish_idle("ae");

    // flush right after the first pop
    do_reset();
    load(3, 1'b1, 1);
    bus.out_ready = 1'b1;
    enable = 1'b1;
    k = 0;
    while (!bus.Fifo_rd && k < 20) begin step(); k++; end
    check("flush_pop_seen", 32'(bus.Fifo_rd), 32'(1));
    check("flush_state_read", 32'(state), 32'(1));
    enable = 1'b0;
    step();
    check("flush_state_flush", 32'(state), 32'(3));
    k = 0;
    while (state != 2'd0 && k < 10) begin step(); k++; end
    check("flush_state_idle", 32'(state), 32'(0));
    wait_drain("flush_drain", 10, 1'b0);
    repeat (4) step();
    check("flush_pops", 32'(pops), 32'(1));
    check("flush_left", 32'(fifo_q.size()), 32'(2));
    check("flush_idle", 32'(idle), 32'(1));

    // simultaneous error causes count once per cycle
    do_reset();
    force_vr = 1'b1;
    force_err = 1'b1;
    repeat (3) step();
    force_vr = 1'b0;
    force_err = 1'b0;
    repeat (3) step();
    check("err_merge", 32'(err_count), 32'(3));
    check("err_merge_valid", 32'(bus.data_valid), 32'(0));

    // saturation
    do_reset();
    force_vr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("sat_no_word", 32'(bus.data_valid), 32'(0));
    end
    force_vr = 1'b0;
    repeat (3) step();
    check("sat_err", 32'(err_count), 32'(15));
    check("sat_valid", 32'(bus.data_valid), 32'(0));

    // reset mid-burst
    do_reset();
    load(8, 1'b1, 0);
    enable = 1'b1;
    k = 0;
    while (!bus.data_valid && k < 30) begin step(); k++; end
    check("mid_burst_reached", 32'(bus.data_valid), 32'(1));
    reset = 1'b0;
    enable = 1'b0;
    step();
    check("mid_rst_fifo_rd", 32'(bus.Fifo_rd), 32'(0));
    check("mid_rst_valid", 32'(bus.data_valid), 32'(0));
    check("mid_rst_data", 32'(bus.data_out), 32'(0));
    check("mid_rst_err", 32'(err_count), 32'(0));
    check("mid_rst_idle", 32'(idle), 32'(1));
    repeat (3) step();
    fifo_q.delete();
    exp_q.delete();
    reset = 1'b1;
    repeat (4) step();
    check("mid_post_err", 32'(err_count), 32'(0));
    check("mid_post_valid", 32'(bus.data_valid), 32'(0));
    check("mid_post_idle", 32'(idle), 32'(1));

    // randomized bursts with random backpressure and can_pop
    for (int it = 0; it < 12; it++) begin
      do_reset();
      n = $urandom_range(1, 12);
      load(n, 1'b1, n);
      enable = 1'b1;
      wait_drain("rnd_drain", 400, 1'b1);
      finish_idle("rnd");
      check("rnd_pops", 32'(pops), 32'(n));
      check("rnd_underflow", 32'(underflows), 32'(0));
      check("rnd_deliveries", 32'(deliveries), 32'(n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
